// File: rtl/vip_axi4_pkg.sv
// Shared AXI4 VIP configuration types.
//   vip_axi4_cfg_t : bus geometry; checkers pick out the fields they need.
package vip_axi4_pkg;

  typedef struct packed {
    int unsigned VIP_AXI4_ID_WIDTH_P;
    int unsigned VIP_AXI4_ADDR_WIDTH_P;
    int unsigned VIP_AXI4_DATA_WIDTH_P;
  } vip_axi4_cfg_t;

endpackage

// File: rtl/vip_axi4_wr_checker.sv
// Passive AXI4 write-channel checker: pairs AW burst lengths with counted W
// bursts, tracks bursts awaiting B, and watches for stalled handshakes.
// Errors are sticky flags plus a one-cycle pulse and first-error capture.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   awid/awlen/awvalid/awready   monitored AW channel
//   wlast/wvalid/wready          monitored W channel
//   bid/bvalid/bready            monitored B channel
//   clear_err       synchronous clear of flags and first-error capture
//   err_flags       {TIMEOUT, B_UNEXPECTED, W_OVERFLOW, AW_OVERFLOW,
//                    WLAST_MISSING, WLEN_MISMATCH}
//   err_pulse       one cycle when any flag rises
//   first_err_idx   lowest flag index of the first error since reset/clear
//   first_err_id    awid (bid for B_UNEXPECTED) at the first error
//   pending_aw      AW bursts not yet paired with W data
//   pending_b       paired bursts awaiting a B handshake
module vip_axi4_wr_checker
  import vip_axi4_pkg::*;
#(
  parameter vip_axi4_cfg_t CFG_P             = '{default: '0},
  parameter int unsigned   MAX_OUTSTANDING_P = 8,
  parameter int unsigned   TIMEOUT_P         = 1024,
  localparam int unsigned  ID_W = (CFG_P.VIP_AXI4_ID_WIDTH_P == 0) ? 1 : CFG_P.VIP_AXI4_ID_WIDTH_P,
  localparam int unsigned  PW   = $clog2(MAX_OUTSTANDING_P) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ID_W-1:0] awid,
  input  logic [7:0]      awlen,
  input  logic            awvalid,
  input  logic            awready,
  input  logic            wlast,
  input  logic            wvalid,
  input  logic            wready,
  input  logic [ID_W-1:0] bid,
  input  logic            bvalid,
  input  logic            bready,
  input  logic            clear_err,
  output logic [5:0]      err_flags,
  output logic            err_pulse,
  output logic [2:0]      first_err_idx,
  output logic [ID_W-1:0] first_err_id,
  output logic [PW-1:0]   pending_aw,
  output logic [PW-1:0]   pending_b
);

  localparam int unsigned DEPTH  = MAX_OUTSTANDING_P;
  localparam int unsigned IW     = $clog2(DEPTH);
  localparam int unsigned LW     = 9;
  // Largest value the pending_b port can carry.
  localparam int unsigned PB_MAX = 2 * DEPTH - 1;
  localparam int unsigned TW     = (TIMEOUT_P == 0) ? 1 : $clog2(TIMEOUT_P + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_P);
  localparam logic [TW-1:0] TO_PRE = TW'(TIMEOUT_P - 1);

  localparam logic [LW-1:0] BEAT_SAT = 9'd256;

  // Length FIFOs
  logic [LW-1:0] aw_mem_q [DEPTH];
  logic [LW-1:0] w_mem_q  [DEPTH];
  logic [IW-1:0] aw_wptr_q, aw_wptr_d, aw_rptr_q, aw_rptr_d;
  logic [IW-1:0] w_wptr_q,  w_wptr_d,  w_rptr_q,  w_rptr_d;
  logic [PW-1:0] aw_cnt_q,  aw_cnt_d,  w_cnt_q,   w_cnt_d;

  logic [LW-1:0] beat_q, beat_d;
  logic [PW-1:0] pb_q, pb_d;
  logic [TW-1:0] to_aw_q, to_aw_d, to_w_q, to_w_d, to_b_q, to_b_d;

  logic [5:0]      flags_q, flags_d;
  logic            pulse_q, pulse_d;
  logic [2:0]      fidx_q, fidx_d;
  logic [ID_W-1:0] fid_q, fid_d;
  logic            fvalid_q, fvalid_d;

  logic          aw_hs, w_hs, b_hs;
  logic          aw_full, w_full, pair;
  logic          aw_push, w_push;
  logic [LW-1:0] aw_len_val, w_len_val;
  logic [PW:0]   pb_avail, pb_next;
  logic [5:0]    new_err, base_flags;
  logic [2:0]    lo_idx;
  logic          stall_aw, stall_w, stall_b;

  // Stall counter: counts while stalled, holds at the limit, clears otherwise.
  function automatic logic [TW-1:0] to_next(input logic stall, input logic [TW-1:0] cnt);
    if (!stall) return '0;
    if (cnt == TO_LIM) return cnt;
    return cnt + TW'(1);
  endfunction

  // True only on the cycle the counter reaches the limit, so the flag fires once.
  function automatic logic to_hit(input logic stall, input logic [TW-1:0] cnt);
    return (TIMEOUT_P != 0) && stall && (cnt == TO_PRE);
  endfunction

  // Next-state and error detection
  always_comb begin
    aw_hs      = awvalid && awready;
    w_hs       = wvalid && wready;
    b_hs       = bvalid && bready;
    stall_aw   = awvalid && !awready;
    stall_w    = wvalid && !wready;
    stall_b    = bvalid && !bready;

    aw_full    = (aw_cnt_q == PW'(DEPTH));
    w_full     = (w_cnt_q == PW'(DEPTH));
    // Pairing is decided from registered occupancy only.
    pair       = (aw_cnt_q != '0) && (w_cnt_q != '0);

    aw_len_val = {1'b0, awlen} + 9'd1;
    w_len_val  = beat_q + 9'd1;

    new_err    = '0;
    new_err[0] = pair && (aw_mem_q[aw_rptr_q] != w_mem_q[w_rptr_q]);

    // A full FIFO still accepts a push when its head pops in the same cycle.
    aw_push    = aw_hs && (!aw_full || pair);
    new_err[2] = aw_hs && aw_full && !pair;
    w_push     = w_hs && wlast && (!w_full || pair);
    new_err[3] = w_hs && wlast && w_full && !pair;

    beat_d     = beat_q;
    if (w_hs) begin
      if (wlast) begin
        beat_d = '0;
      end else if (beat_q == BEAT_SAT) begin
        new_err[1] = 1'b1;
      end else begin
        beat_d = beat_q + 9'd1;
      end
    end

    aw_wptr_d  = aw_wptr_q + IW'(aw_push);
    aw_rptr_d  = aw_rptr_q + IW'(pair);
    aw_cnt_d   = aw_cnt_q + PW'(aw_push) - PW'(pair);
    w_wptr_d   = w_wptr_q + IW'(w_push);
    w_rptr_d   = w_rptr_q + IW'(pair);
    w_cnt_d    = w_cnt_q + PW'(w_push) - PW'(pair);

    // A same-cycle pair makes a B handshake legal even when pending_b is 0.
    pb_avail   = {1'b0, pb_q} + (PW+1)'(pair);
    new_err[4] = b_hs && (pb_avail == '0);
    pb_next    = pb_avail - (PW+1)'(b_hs && (pb_avail != '0));
    pb_d       = (pb_next > (PW+1)'(PB_MAX)) ? PW'(PB_MAX) : pb_next[PW-1:0];

    to_aw_d    = to_next(stall_aw, to_aw_q);
    to_w_d     = to_next(stall_w, to_w_q);
    to_b_d     = to_next(stall_b, to_b_q);
    new_err[5] = to_hit(stall_aw, to_aw_q) || to_hit(stall_w, to_w_q) || to_hit(stall_b, to_b_q);

    // A clear and a new error in the same cycle: the new error survives.
    base_flags = clear_err ? '0 : flags_q;
    flags_d    = base_flags | new_err;
    pulse_d    = |(new_err & ~base_flags);

    lo_idx     = '0;
    for (int i = 5; i >= 0; i--) begin
      if (new_err[i]) lo_idx = 3'(i);
    end

    fvalid_d   = clear_err ? 1'b0 : fvalid_q;
    fidx_d     = clear_err ? '0 : fidx_q;
    fid_d      = clear_err ? '0 : fid_q;
    if ((new_err != '0) && !fvalid_d) begin
      fvalid_d = 1'b1;
      fidx_d   = lo_idx;
      fid_d    = (lo_idx == 3'd4) ? bid : awid;
    end
  end

  // State registers and FIFO storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        aw_mem_q[i] <= '0;
        w_mem_q[i]  <= '0;
      end
      aw_wptr_q <= '0;
      aw_rptr_q <= '0;
      aw_cnt_q  <= '0;
      w_wptr_q  <= '0;
      w_rptr_q  <= '0;
      w_cnt_q   <= '0;
      beat_q    <= '0;
      pb_q      <= '0;
      to_aw_q   <= '0;
      to_w_q    <= '0;
      to_b_q    <= '0;
      flags_q   <= '0;
      pulse_q   <= 1'b0;
      fidx_q    <= '0;
      fid_q     <= '0;
      fvalid_q  <= 1'b0;
    end else begin
      if (aw_push) aw_mem_q[aw_wptr_q] <= aw_len_val;
      if (w_push)  w_mem_q[w_wptr_q]   <= w_len_val;
      aw_wptr_q <= aw_wptr_d;
      aw_rptr_q <= aw_rptr_d;
      aw_cnt_q  <= aw_cnt_d;
      w_wptr_q  <= w_wptr_d;
      w_rptr_q  <= w_rptr_d;
      w_cnt_q   <= w_cnt_d;
      beat_q    <= beat_d;
      pb_q      <= pb_d;
      to_aw_q   <= to_aw_d;
      to_w_q    <= to_w_d;
      to_b_q    <= to_b_d;
      flags_q   <= flags_d;
      pulse_q   <= pulse_d;
      fidx_q    <= fidx_d;
      fid_q     <= fid_d;
      fvalid_q  <= fvalid_d;
    end
  end

  assign err_flags     = flags_q;
  assign err_pulse     = pulse_q;
  assign first_err_idx = fidx_q;
  assign first_err_id  = fid_q;
  assign pending_aw    = aw_cnt_q;
  assign pending_b     = pb_q;

endmodule

// File: tb/tb_vip_axi4_wr_checker.sv
// Scoreboard bench for vip_axi4_wr_checker: a queue-based burst model predicts
// the outputs after every clock edge; a negedge monitor pops and compares.
module tb_vip_axi4_wr_checker;
  import vip_axi4_pkg::*;

  localparam int unsigned D   = 4;
  localparam int unsigned T   = 16;
  localparam int unsigned IDW = 4;
  localparam int unsigned PW  = 3;
  localparam vip_axi4_cfg_t CFG = '{VIP_AXI4_ID_WIDTH_P: 4, VIP_AXI4_ADDR_WIDTH_P: 32,
                                    VIP_AXI4_DATA_WIDTH_P: 32};

  logic           clk, rst_n;
  logic [IDW-1:0] awid, bid;
  logic [7:0]     awlen;
  logic           awvalid, awready, wlast, wvalid, wready, bvalid, bready, clear_err;
  logic [5:0]     err_flags;
  logic           err_pulse;
  logic [2:0]     first_err_idx;
  logic [IDW-1:0] first_err_id;
  logic [PW-1:0]  pending_aw, pending_b;

  vip_axi4_wr_checker #(.CFG_P(CFG), .MAX_OUTSTANDING_P(D), .TIMEOUT_P(T)) dut (
    .clk(clk), .rst_n(rst_n), .awid(awid), .awlen(awlen), .awvalid(awvalid),
    .awready(awready), .wlast(wlast), .wvalid(wvalid), .wready(wready), .bid(bid),
    .bvalid(bvalid), .bready(bready), .clear_err(clear_err), .err_flags(err_flags),
    .err_pulse(err_pulse), .first_err_idx(first_err_idx), .first_err_id(first_err_id),
    .pending_aw(pending_aw), .pending_b(pending_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [5:0]     flags;
    logic           pulse;
    logic [2:0]     idx;
    logic [IDW-1:0] id;
    logic [PW-1:0]  paw;
    logic [PW-1:0]  pb;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: bursts as queues of lengths, counts as plain integers.
  int       m_awq[$];
  int       m_wq[$];
  int       m_beats, m_pb, m_idx, m_id;
  int       m_to[3];
  bit [5:0] m_flags;
  bit       m_pulse, m_fv;

  function automatic void model_reset();
    m_awq.delete();
    m_wq.delete();
    m_beats = 0; m_pb = 0; m_idx = 0; m_id = 0;
    for (int c = 0; c < 3; c++) m_to[c] = 0;
    m_flags = '0; m_pulse = 0; m_fv = 0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.flags = m_flags;
    e.pulse = m_pulse;
    e.idx   = 3'(m_idx);
    e.id    = IDW'(m_id);
    e.paw   = PW'(m_awq.size());
    e.pb    = PW'(m_pb);
    return e;
  endfunction

  function automatic void model_step();
    bit [5:0] ne;
    bit [5:0] base;
    bit       pair;
    bit       stall[3];
    int       a, w, avail;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ne   = '0;
    pair = (m_awq.size() > 0) && (m_wq.size() > 0);
    if (pair) begin
      a = m_awq.pop_front();
      w = m_wq.pop_front();
      if (a != w) ne[0] = 1'b1;
    end
    if (awvalid && awready) begin
      if (m_awq.size() >= D) ne[2] = 1'b1;
      else m_awq.push_back(int'(awlen) + 1);
    end
    if (wvalid && wready) begin
      if (wlast) begin
        if (m_wq.size() >= D) ne[3] = 1'b1;
        else m_wq.push_back(m_beats + 1);
        m_beats = 0;
      end else if (m_beats == 256) begin
        ne[1] = 1'b1;
      end else begin
        m_beats++;
      end
    end
    avail = m_pb + (pair ? 1 : 0);
    if (bvalid && bready) begin
      if (avail > 0) avail--;
      else ne[4] = 1'b1;
    end
    m_pb = (avail > 2 * D - 1) ? 2 * D - 1 : avail;
    stall[0] = awvalid && !awready;
    stall[1] = wvalid && !wready;
    stall[2] = bvalid && !bready;
    for (int c = 0; c < 3; c++) begin
      if (stall[c]) begin
        if (m_to[c] == T - 1) ne[5] = 1'b1;
        if (m_to[c] < T) m_to[c]++;
      end else begin
        m_to[c] = 0;
      end
    end
    base    = clear_err ? 6'b0 : m_flags;
    m_pulse = |(ne & ~base);
    m_flags = base | ne;
    if (clear_err) begin
      m_fv = 0; m_idx = 0; m_id = 0;
    end
    if (ne != 0 && !m_fv) begin
      for (int i = 5; i >= 0; i--) if (ne[i]) m_idx = i;
      m_id = (m_idx == 4) ? int'(bid) : int'(awid);
      m_fv = 1;
    end
  endfunction

  // One clock: model consumes the inputs the DUT samples, then inputs may change.
  task automatic tick();
    @(posedge clk);
    model_step();
    expq.push_back(model_out());
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic do_aw(input int len);
    awvalid = 1; awready = 1; awlen = 8'(len); awid = IDW'($urandom);
    tick();
    awvalid = 0; awready = 0;
  endtask

  task automatic do_w(input bit last);
    wvalid = 1; wready = 1; wlast = last;
    tick();
    wvalid = 0; wready = 0; wlast = 0;
  endtask

  task automatic do_b(input int id);
    bvalid = 1; bready = 1; bid = IDW'(id);
    tick();
    bvalid = 0; bready = 0;
  endtask

  task automatic do_clear();
    clear_err = 1;
    tick();
    clear_err = 0;
  endtask

  task automatic idle_inputs();
    awvalid = 0; awready = 0; awlen = '0; awid = '0;
    wvalid = 0; wready = 0; wlast = 0;
    bvalid = 0; bready = 0; bid = '0; clear_err = 0;
  endtask

  // Asynchronous reset between edges: outputs drop before the next sample.
  task automatic do_reset();
    rst_n = 0;
    model_reset();
    expq.delete();
    expq.push_back(model_out());
    #1;
    chk("reset_async_flags", int'(err_flags), 0);
    chk("reset_async_pend_aw", int'(pending_aw), 0);
    chk("reset_async_pend_b", int'(pending_b), 0);
    chk("reset_async_idx", int'(first_err_idx), 0);
    repeat (2) tick();
    rst_n = 1;
  endtask

  // Monitor: every negedge the DUT presents its registered outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        e = expq.pop_front();
        if (err_flags !== e.flags || err_pulse !== e.pulse || first_err_idx !== e.idx ||
            first_err_id !== e.id || pending_aw !== e.paw || pending_b !== e.pb) begin
          fails++;
          $display("FAIL outputs at %0t: got flags=%b pulse=%b idx=%0d id=%0d paw=%0d pb=%0d expected flags=%b pulse=%b idx=%0d id=%0d paw=%0d pb=%0d",
                   $time, err_flags, err_pulse, first_err_idx, first_err_id, pending_aw, pending_b,
                   e.flags, e.pulse, e.idx, e.id, e.paw, e.pb);
        end
      end
    end
  end

  initial begin
    rst_n = 0;
    idle_inputs();
    model_reset();
    repeat (3) tick();
    chk("reset_flags", int'(err_flags), 0);
    chk("reset_pulse", int'(err_pulse), 0);
    chk("reset_pend_aw", int'(pending_aw), 0);
    chk("reset_pend_b", int'(pending_b), 0);
    rst_n = 1;
    tick();

    // Matched 4-beat burst
    do_aw(3);
    chk("s1_pend_aw_after_aw", int'(pending_aw), 1);
    repeat (3) do_w(0);
    do_w(1);
    tick();
    chk("s1_pend_aw_after_pair", int'(pending_aw), 0);
    chk("s1_pend_b_after_pair", int'(pending_b), 1);
    do_b(0);
    chk("s1_pend_b_after_b", int'(pending_b), 0);
    chk("s1_flags", int'(err_flags), 0);

    // W data ahead of AW
    do_w(0);
    do_w(1);
    do_aw(1);
    tick();
    do_b(1);
    chk("s2_flags", int'(err_flags), 0);
    chk("s2_pend_b", int'(pending_b), 0);

    // Short burst against AWLEN=7
    do_aw(7);
    repeat (4) do_w(0);
    do_w(1);
    tick();
    chk("s3_flags", int'(err_flags), 1);
    chk("s3_pulse", int'(err_pulse), 1);
    chk("s3_idx", int'(first_err_idx), 0);
    tick();
    chk("s3_pulse_drop", int'(err_pulse), 0);
    chk("s3_flags_sticky", int'(err_flags), 1);
    do_b(0);
    do_clear();
    chk("s3_clear", int'(err_flags), 0);

    // Unexpected B
    do_b(3);
    chk("s4_flags", int'(err_flags), 6'b010000);
    chk("s4_id", int'(first_err_id), 3);
    chk("s4_idx", int'(first_err_idx), 4);
    chk("s4_pend_b", int'(pending_b), 0);
    do_clear();

    // AW FIFO overflow, then drain
    repeat (D + 1) do_aw(0);
    chk("s5_aw_ovf", int'(err_flags), 6'b000100);
    chk("s5_pend_aw", int'(pending_aw), D);
    repeat (D) do_w(1);
    tick();
    chk("s5_pend_aw_drained", int'(pending_aw), 0);
    chk("s5_pend_b", int'(pending_b), D);
    repeat (D) do_b(0);
    do_clear();

    // 257 beats without WLAST
    repeat (256) do_w(0);
    chk("s5_256_beats_ok", int'(err_flags), 0);
    do_w(0);
    chk("s5_wlast_missing", int'(err_flags), 6'b000010);
    chk("s5_wlast_idx", int'(first_err_idx), 1);
    do_w(1);
    do_aw(255);
    tick();
    chk("s5_257_mismatch", int'(err_flags), 6'b000011);
    do_b(0);
    do_clear();

    // AW stall timeout
    awvalid = 1; awready = 0;
    repeat (15) tick();
    chk("s6_no_timeout_yet", int'(err_flags), 0);
    tick();
    chk("s6_timeout", int'(err_flags), 6'b100000);
    chk("s6_timeout_idx", int'(first_err_idx), 5);
    awvalid = 0;
    tick();
    do_clear();
    chk("s6_clear", int'(err_flags), 0);

    // Reset in the middle of a burst with a flag pending
    do_b(5);
    do_aw(3);
    do_w(0);
    do_w(0);
    do_reset();
    tick();

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      awvalid = 1'($urandom_range(0, 1)); awready = 1'($urandom_range(0, 1));
      awlen = 8'($urandom_range(0, 3)); awid = IDW'($urandom);
      wvalid = 1'($urandom_range(0, 1)); wready = 1'($urandom_range(0, 1));
      wlast = ($urandom_range(0, 3) == 0);
      bvalid = ($urandom_range(0, 2) == 0); bready = 1'($urandom_range(0, 1));
      bid = IDW'($urandom);
      clear_err = ($urandom_range(0, 31) == 0);
      // Long stretches with rare readies provoke timeouts.
      if (n >= 1500 && n < 1800) begin
        awready = ($urandom_range(0, 23) == 0);
        wready  = ($urandom_range(0, 23) == 0);
        bready  = ($urandom_range(0, 23) == 0);
      end
      tick();
      if (n == 2200) do_reset();
    end
    idle_inputs();
    repeat (4) tick();

    @(negedge clk);
    #1;
    chk("scoreboard_drained", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
